id_stage_s: RTL

Pipeline decode stage for the 5-stage RV32I core. It sits directly downstream of the fetch stage and consumes its `is_valid`/`pc`/`instr` outputs. It also owns the 32×32 register file, which the writeback stage writes, and detects load-use hazards, driving the stall back to fetch. Decoded fields, operands and control go to execute through a registered ID/EX boundary.

---
 rtl/id_stage_s_if.sv | 47 ++++
 rtl/id_stage_s.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_s_if.sv
// Fetch/writeback-to-decode bus and ID/EX outputs of id_stage_s.
// master = upstream fetch/writeback side, slave = the decode stage.
interface id_stage_s_if;
  logic        is_flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        is_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic [6:0]  id_opcode;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        id_branch;
  logic        id_jump;
  logic        id_illegal;

  modport master (
    output is_flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
    input  is_stall, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_opcode,
    input  id_alu_src, id_mem_read, id_mem_write, id_reg_write,
    input  id_branch, id_jump, id_illegal
  );

  modport slave (
    input  is_flush, if_valid, if_pc, if_instr, wb_we, wb_rd, wb_data,
    output is_stall, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_funct3, id_funct7b5, id_opcode,
    output id_alu_src, id_mem_read, id_mem_write, id_reg_write,
    output id_branch, id_jump, id_illegal
  );
endinterface

// File: rtl/id_stage_s.sv
// RV32I decode stage: register file, decoder, load-use hazard detection, ID/EX register.
// Optional macro WB_BYPASS_EN: writeback write-through on register reads.
module id_stage_s (
  input  logic         clk,
  input  logic         reset,
  id_stage_s_if.slave  bus
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctl_t;

  logic [31:0] instr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  ctl_t        ctl;
  logic [31:0] imm;
  logic        uses_rs1;
  logic        uses_rs2;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        bubble;

  logic [31:0] regs [32];

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic        funct7b5_q;
  logic [6:0]  opcode_q;
  ctl_t        ctl_q;

  assign instr = bus.if_instr;
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rd    = instr[11:7];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_we && bus.wb_rd != '0) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    logic [31:0] val;
    val = regs[idx];
`ifdef WB_BYPASS_EN
    if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == idx) begin
      val = bus.wb_data;
    end
`else
`endif
    if (idx == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rs1_data = rf_read(rs1);
    rs2_data = rf_read(rs2);
  end

  always_comb begin
    ctl      = '0;
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (instr[6:0])
      OP_R: begin
        ctl.reg_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_IMM: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm           = {{20{instr[31]}}, instr[31:20]};
        uses_rs1      = 1'b1;
      end
      OP_LOAD: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        ctl.mem_read  = 1'b1;
        imm           = {{20{instr[31]}}, instr[31:20]};
        uses_rs1      = 1'b1;
      end
      OP_STORE: begin
        ctl.mem_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm           = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        ctl.branch = 1'b1;
        imm        = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
      end
      OP_JAL: begin
        ctl.jump      = 1'b1;
        ctl.reg_write = 1'b1;
        imm           = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
      end
      OP_JALR: begin
        ctl.jump      = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm           = {{20{instr[31]}}, instr[31:20]};
        uses_rs1      = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctl.reg_write = 1'b1;
        ctl.alu_src   = 1'b1;
        imm           = {instr[31:12], 12'b0};
      end
      default: begin
        ctl.illegal = 1'b1;
      end
    endcase
  end

  // Flush is folded into the stall term so a flushed cycle never also stalls fetch.
  always_comb begin
    stall = valid_q && ctl_q.mem_read && (rd_q != '0) && bus.if_valid &&
            !bus.is_flush &&
            ((uses_rs1 && rs1 == rd_q) || (uses_rs2 && rs2 == rd_q));
    bubble = bus.is_flush || stall || !bus.if_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      opcode_q   <= '0;
      ctl_q      <= '0;
    end else begin
      valid_q    <= !bubble;
      pc_q       <= bus.if_pc;
      rs1_data_q <= rs1_data;
      rs2_data_q <= rs2_data;
      imm_q      <= imm;
      rs1_q      <= rs1;
      rs2_q      <= rs2;
      rd_q       <= rd;
      funct3_q   <= instr[14:12];
      funct7b5_q <= instr[30];
      opcode_q   <= instr[6:0];
      ctl_q      <= bubble ? '0 : ctl;
    end
  end

  assign bus.is_stall     = stall;
  assign bus.id_valid     = valid_q;
  assign bus.id_pc        = pc_q;
  assign bus.id_rs1_data  = rs1_data_q;
  assign bus.id_rs2_data  = rs2_data_q;
  assign bus.id_imm       = imm_q;
  assign bus.id_rs1       = rs1_q;
  assign bus.id_rs2       = rs2_q;
  assign bus.id_rd        = rd_q;
  assign bus.id_funct3    = funct3_q;
  assign bus.id_funct7b5  = funct7b5_q;
  assign bus.id_opcode    = opcode_q;
  assign bus.id_alu_src   = ctl_q.alu_src;
  assign bus.id_mem_read  = ctl_q.mem_read;
  assign bus.id_mem_write = ctl_q.mem_write;
  assign bus.id_reg_write = ctl_q.reg_write;
  assign bus.id_branch    = ctl_q.branch;
  assign bus.id_jump      = ctl_q.jump;
  assign bus.id_illegal   = ctl_q.illegal;

endmodule
